// File: rtl/bridge_tx_sched_if.sv
// Handshake bundle between the bridge byte FIFO, the UART transmitter and
// the transmit scheduler.
//   master : the scheduler side (pops the FIFO, strobes the UART, reports status)
//   slave  : the FIFO/UART/status side
// Signals:
//   fifo_empty, fifo_data, fifo_rd_en : FIFO pop interface
//   tx_active, tx_done, tx_dv, tx_byte: UART transmit interface
//   i2c_stop                          : end-of-I2C-transaction pulse
//   busy, byte_count, err_timeout     : scheduler status
interface bridge_tx_sched_if #(
    parameter int unsigned CNT_W = 16
);
    logic             fifo_empty;
    logic [7:0]       fifo_data;
    logic             fifo_rd_en;
    logic             tx_active;
    logic             tx_done;
    logic             i2c_stop;
    logic             tx_dv;
    logic [7:0]       tx_byte;
    logic             busy;
    logic [CNT_W-1:0] byte_count;
    logic             err_timeout;

    modport master (
        input  fifo_empty, fifo_data, tx_active, tx_done, i2c_stop,
        output fifo_rd_en, tx_dv, tx_byte, busy, byte_count, err_timeout
    );

    modport slave (
        output fifo_empty, fifo_data, tx_active, tx_done, i2c_stop,
        input  fifo_rd_en, tx_dv, tx_byte, busy, byte_count, err_timeout
    );
endinterface

// File: rtl/bridge_tx_sched.sv
// Transmit scheduler between the bridge byte FIFO and the UART transmitter.
// Pops one byte when the FIFO has data and the UART is idle, issues a
// single-cycle data-valid strobe, waits for tx_done (supervised by a
// timeout), then inserts an optional inter-byte gap. Counts sent bytes.
// Optional feature macro: EOL_INSERT_EN -- after an i2c_stop pulse, once the
// FIFO has drained, a CR (8'h0D) then LF (8'h0A) pair is transmitted.
// Ports:
//   clk   : bridge clock
//   reset : asynchronous, active-high; clears all state
//   bus   : bridge_tx_sched_if.master (FIFO pop, UART strobe, status)
// Parameters: GAP_CYCLES (idle clocks after tx_done), TIMEOUT (>=1, clocks
// allowed in WAIT_DONE), CNT_W (byte_count width).
module bridge_tx_sched #(
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned CNT_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    bridge_tx_sched_if.master  bus
);
    // One counter serves both the WAIT_DONE timeout and the GAP length.
    localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_CAPT   = 3'd2,
        S_LAUNCH = 3'd3,
        S_WAIT   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_fifo_rd_en, r_tx_dv, r_busy, r_err_timeout;
    logic [7:0]       r_tx_byte, w_tx_byte;
    logic [CNT_W-1:0] r_byte_count;
    logic             w_tx_dv, w_done, w_timeout;

`ifdef EOL_INSERT_EN
    logic r_stop_pending, r_lf_pending, r_is_cr;
    logic w_start_cr, w_start_lf;
`else
    logic w_unused_stop;
    assign w_unused_stop = bus.i2c_stop;
`endif

    always_comb begin
        w_next    = r_state;
        w_tx_byte = r_tx_byte;
        w_tx_dv   = 1'b0;
        w_done    = 1'b0;
        w_timeout = 1'b0;
`ifdef EOL_INSERT_EN
        w_start_cr = 1'b0;
        w_start_lf = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!bus.fifo_empty && !bus.tx_active) begin
                    w_next = S_READ;
                end
`ifdef EOL_INSERT_EN
                // FIFO data always drains before the CR/LF pair.
                else if (bus.fifo_empty && r_lf_pending) begin
                    w_next     = S_LAUNCH;
                    w_tx_byte  = 8'h0A;
                    w_start_lf = 1'b1;
                end else if (bus.fifo_empty && r_stop_pending) begin
                    w_next     = S_LAUNCH;
                    w_tx_byte  = 8'h0D;
                    w_start_cr = 1'b1;
                end
`endif
            end
            S_READ: w_next = S_CAPT;
            S_CAPT: begin
                w_tx_byte = bus.fifo_data;
                w_next    = S_LAUNCH;
            end
            S_LAUNCH: begin
                if (!bus.tx_active) begin
                    w_tx_dv = 1'b1;
                    w_next  = S_WAIT;
                end
            end
            S_WAIT: begin
                // tx_done wins over a timeout expiring in the same cycle.
                if (bus.tx_done) begin
                    w_done = 1'b1;
                    w_next = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            S_GAP: begin
                if (r_cnt == CW'(GAP_CYCLES - 1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so each strobe
    // coincides with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_fifo_rd_en  <= 1'b0;
            r_tx_dv       <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_byte     <= '0;
            r_byte_count  <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state != w_next)
                r_cnt <= '0;
            else if (r_state == S_WAIT || r_state == S_GAP)
                r_cnt <= r_cnt + 1'b1;
            r_fifo_rd_en <= (w_next == S_READ);
            r_tx_dv      <= w_tx_dv;
            r_busy       <= (w_next != S_IDLE);
            r_tx_byte    <= w_tx_byte;
            if (w_done)    r_byte_count  <= r_byte_count + 1'b1;
            if (w_timeout) r_err_timeout <= 1'b1;
        end
    end

`ifdef EOL_INSERT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stop_pending <= 1'b0;
            r_lf_pending   <= 1'b0;
            r_is_cr        <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_is_cr <= w_start_cr;
            // Launching the CR consumes the stop request and arms the LF;
            // a stop pulse in that same cycle is absorbed.
            if (w_tx_dv && r_is_cr) begin
                r_stop_pending <= 1'b0;
                r_lf_pending   <= 1'b1;
            end else begin
                if (bus.i2c_stop) r_stop_pending <= 1'b1;
                if (w_start_lf || (w_timeout && r_is_cr)) r_lf_pending <= 1'b0;
            end
        end
    end
`endif

    assign bus.fifo_rd_en  = r_fifo_rd_en;
    assign bus.tx_dv       = r_tx_dv;
    assign bus.tx_byte     = r_tx_byte;
    assign bus.busy        = r_busy;
    assign bus.byte_count  = r_byte_count;
    assign bus.err_timeout = r_err_timeout;
endmodule
